// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Receive-side control for an asynchronous serial line. The rx line is
// synchronized, a falling edge in IDLE fires rx_start (which reloads an
// external baud counter to the half-bit point), and every baud_comp tick
// then samples the start, data, optional parity and stop bits. A finished
// frame lands in rx_data with its error flags. A frame that arrives while
// the previous word is still unread is dropped and flagged as an overrun.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   rx           asynchronous serial input, idle high
//   baud_comp    one-cycle tick at each bit-sample point
//   parity_en    frame carries a parity bit after the data bits
//   parity_odd   1 = odd parity, 0 = even
//   data_ready   consumer takes rx_data when high together with rx_valid
//   err_clr      one-cycle pulse clearing overrun_err
//   rx_start     one-cycle pulse reloading the baud counter
//   rx_data      last received word, LSB first on the line
//   rx_valid     rx_data holds an unread word
//   frame_err    stop bit of the word in rx_data sampled low
//   parity_err   parity mismatch for the word in rx_data
//   overrun_err  sticky: a completed frame was dropped
//   busy         receiver is not idle
module uart_rx_ctrl #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              baud_comp,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              data_ready,
    input  logic              err_clr,
    output logic              rx_start,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              parity_err,
    output logic              overrun_err,
    output logic              busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rx_s;
    logic                   rx_q;
    logic [2:0]             state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      shreg;
    logic                   par_en_l;
    logic                   par_odd_l;
    logic                   par_bad;
    logic                   accept;

    assign rx_s = sync[SYNC_STAGES-1];
    assign busy = (state != IDLE);

    // The previous word may be replaced only if it is gone or being taken now.
    assign accept = !rx_valid || data_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync        <= '1;
            rx_q        <= 1'b1;
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            par_en_l    <= 1'b0;
            par_odd_l   <= 1'b0;
            par_bad     <= 1'b0;
            rx_start    <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            sync     <= {sync[SYNC_STAGES-2:0], rx};
            rx_q     <= rx_s;
            rx_start <= 1'b0;

            if (rx_valid && data_ready) begin
                rx_valid <= 1'b0;
            end
            if (err_clr) begin
                overrun_err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // Only a true high-to-low transition starts a frame, so a
                    // line parked low after a break cannot retrigger.
                    if (rx_q && !rx_s) begin
                        rx_start <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_comp) begin
                        if (!rx_s) begin
                            state     <= DATA;
                            bit_cnt   <= '0;
                            par_en_l  <= parity_en;
                            par_odd_l <= parity_odd;
                            par_bad   <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (baud_comp) begin
                        shreg   <= {rx_s, shreg[DATA_W-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(DATA_W-1)) begin
                            state <= par_en_l ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (baud_comp) begin
                        par_bad <= (^shreg) ^ rx_s ^ par_odd_l;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (baud_comp) begin
                        state <= IDLE;
                        if (accept) begin
                            rx_data    <= shreg;
                            frame_err  <= ~rx_s;
                            parity_err <= par_en_l & par_bad;
                            rx_valid   <= 1'b1;
                        end else begin
                            // Overrun wins over a simultaneous err_clr.
                            overrun_err <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a free-running divide-by-16 baud counter that
// rx_start reloads to the half-bit point, a bit-level line driver, a table
// of frames with hand-derived expected words and flags, and hand-written
// sequences for false start, break, overrun and mid-frame reset.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic       baud_comp;
    logic       parity_en;
    logic       parity_odd;
    logic       data_ready;
    logic       err_clr;
    logic       rx_start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int starts = 0;

    logic [3:0] bcnt = 4'd0;
    int         tcnt = 0;
    logic       dr_lvl;
    logic       dr_arm;
    logic       dr_win;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] data;
        bit         pen;
        bit         podd;
        bit         pbit;
        bit         stop;
        logic [7:0] exp_data;
        bit         exp_ferr;
        bit         exp_perr;
    } vec_t;
    vec_t vecs[9];

    uart_rx_ctrl #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx          (rx),
        .baud_comp   (baud_comp),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .data_ready  (data_ready),
        .err_clr     (err_clr),
        .rx_start    (rx_start),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Baud counter: reload takes priority, so no tick in the rx_start cycle.
    always @(posedge clk) begin
        if (rx_start) bcnt <= 4'd8;
        else          bcnt <= bcnt + 4'd1;
    end
    assign baud_comp = (bcnt == 4'd15) && !rx_start;

    // Tick index within a frame: 0 = start bit, 1..8 data, 9 = stop (no parity).
    always @(posedge clk) begin
        if (rx_start)       tcnt <= 0;
        else if (baud_comp) tcnt <= tcnt + 1;
        if (rx_start)       starts <= starts + 1;
    end
    assign dr_win     = dr_arm && baud_comp && (tcnt == 9);
    assign data_ready = dr_lvl | dr_win;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        tick(n);
    endtask

    // Drives start, 8 data bits LSB first, optional parity, stop; 16 clocks
    // per bit. If rst_at >= 0, reset is pulsed at that clock and the frame
    // is abandoned with the line returned high. The stop level is left on rx.
    task automatic send_frame(input logic [7:0] d, input bit pen, input bit pbit,
                              input bit stop, input int rst_at);
        logic bitv[11];
        int   nb;
        int   cyc;
        bitv[0] = 1'b0;
        for (int i = 0; i < 8; i++) bitv[i+1] = d[i];
        nb = 9;
        if (pen) begin
            bitv[nb] = pbit;
            nb++;
        end
        bitv[nb] = stop;
        nb++;
        cyc = 0;
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 16; k++) begin
                rx    = bitv[b];
                reset = (cyc == rst_at);
                @(posedge clk);
                #1;
                if (reset) begin
                    reset = 1'b0;
                    rx    = 1'b1;
                    return;
                end
                cyc++;
            end
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!rx_valid && n < 200) begin
            tick(1);
            n++;
        end
        check(name, {31'd0, rx_valid}, 32'd1);
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check({name, "_data"}, {24'd0, rx_data}, {24'd0, e.data});
        check({name, "_ferr"}, {31'd0, frame_err}, {31'd0, e.ferr});
        check({name, "_perr"}, {31'd0, parity_err}, {31'd0, e.perr});
    endtask

    task automatic consume();
        dr_lvl = 1'b1;
        tick(1);
        dr_lvl = 1'b0;
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_start"}, {31'd0, rx_start}, 32'd0);
        check({name, "_data"}, {24'd0, rx_data}, 32'd0);
        check({name, "_valid"}, {31'd0, rx_valid}, 32'd0);
        check({name, "_ferr"}, {31'd0, frame_err}, 32'd0);
        check({name, "_perr"}, {31'd0, parity_err}, 32'd0);
        check({name, "_ovr"}, {31'd0, overrun_err}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int s0;
        //          data   pen podd pbit stop  exp   ferr perr
        vecs[0] = '{8'hA5, 0, 0, 0, 1, 8'hA5, 0, 0};
        vecs[1] = '{8'h03, 1, 0, 1, 1, 8'h03, 0, 1};
        vecs[2] = '{8'h03, 1, 0, 0, 1, 8'h03, 0, 0};
        vecs[3] = '{8'h55, 0, 0, 0, 0, 8'h55, 1, 0};
        vecs[4] = '{8'h3C, 1, 1, 1, 1, 8'h3C, 0, 0};
        vecs[5] = '{8'h80, 1, 1, 1, 1, 8'h80, 0, 1};
        vecs[6] = '{8'hFF, 0, 1, 1, 1, 8'hFF, 0, 0};
        vecs[7] = '{8'h07, 1, 0, 0, 0, 8'h07, 1, 1};
        vecs[8] = '{8'h00, 0, 0, 0, 1, 8'h00, 0, 0};

        reset      = 1'b1;
        rx         = 1'b1;
        parity_en  = 1'b0;
        parity_odd = 1'b0;
        dr_lvl     = 1'b0;
        dr_arm     = 1'b0;
        err_clr    = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check_reset_vals("reset");
        idle(8);

        // Table of frames
        foreach (vecs[i]) begin
            parity_en  = vecs[i].pen;
            parity_odd = vecs[i].podd;
            sb.push_back('{vecs[i].exp_data, vecs[i].exp_ferr, vecs[i].exp_perr});
            s0 = starts;
            send_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].stop, -1);
            idle(6);
            check($sformatf("vec%0d_starts", i), starts - s0, 1);
            wait_valid($sformatf("vec%0d_valid", i));
            pop_check($sformatf("vec%0d", i));
            check($sformatf("vec%0d_busy", i), {31'd0, busy}, 32'd0);
            consume();
            check($sformatf("vec%0d_cleared", i), {31'd0, rx_valid}, 32'd0);
        end
        parity_en = 1'b0;

        // False start: short low pulse
        s0 = starts;
        rx = 1'b0;
        tick(4);
        check("false_busy", {31'd0, busy}, 32'd1);
        idle(30);
        check("false_starts", starts - s0, 1);
        check("false_idle", {31'd0, busy}, 32'd0);
        check("false_valid", {31'd0, rx_valid}, 32'd0);

        // Break: stop bit low and line held low
        sb.push_back('{8'h55, 1'b1, 1'b0});
        s0 = starts;
        send_frame(8'h55, 0, 0, 0, -1);
        rx = 1'b0;
        tick(60);
        wait_valid("break_valid");
        pop_check("break");
        check("break_no_restart", starts - s0, 1);
        check("break_idle", {31'd0, busy}, 32'd0);
        consume();
        idle(5);
        sb.push_back('{8'h81, 1'b0, 1'b0});
        send_frame(8'h81, 0, 0, 1, -1);
        idle(6);
        check("after_break_starts", starts - s0, 2);
        wait_valid("after_break_valid");
        pop_check("after_break");
        consume();

        // Overrun
        sb.push_back('{8'h11, 1'b0, 1'b0});
        send_frame(8'h11, 0, 0, 1, -1);
        idle(6);
        send_frame(8'h22, 0, 0, 1, -1);
        idle(6);
        check("ovr_valid", {31'd0, rx_valid}, 32'd1);
        check("ovr_flag", {31'd0, overrun_err}, 32'd1);
        pop_check("ovr_held");
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("ovr_clr", {31'd0, overrun_err}, 32'd0);
        check("ovr_clr_valid", {31'd0, rx_valid}, 32'd1);
        sb.push_back('{8'h22, 1'b0, 1'b0});
        dr_arm = 1'b1;
        send_frame(8'h22, 0, 0, 1, -1);
        dr_arm = 1'b0;
        idle(6);
        check("replace_valid", {31'd0, rx_valid}, 32'd1);
        check("replace_ovr", {31'd0, overrun_err}, 32'd0);
        pop_check("replace");
        consume();

        // Reset during data bit 3, then a clean frame
        sb.push_back('{8'hA5, 1'b0, 1'b0});
        send_frame(8'hA5, 0, 0, 1, -1);
        idle(6);
        send_frame(8'h5A, 0, 0, 1, 72);
        check_reset_vals("midrst");
        void'(sb.pop_front());
        idle(20);
        check("midrst_quiet", {31'd0, rx_valid}, 32'd0);
        sb.push_back('{8'hC3, 1'b0, 1'b0});
        send_frame(8'hC3, 0, 0, 1, -1);
        idle(6);
        wait_valid("post_rst_valid");
        pop_check("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
